trap_ctrl: RTL and testbench

//  Trap sequencer that sits directly upstream of the CSR unit. It captures

---
 rtl/trap_pkg.sv | 39 +++
 rtl/trap_prio_enc.sv | 34 +++
 rtl/trap_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_trap_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// -----------------------------------------------------------------------------
// trap_pkg
// Shared definitions for the trap sequencer and the CSR unit.
//   - Exception cause codes (4-bit mcause exception code field).
//   - Machine external interrupt mcause value (XLEN=32 form).
//   - Bit positions of the exception request vector fed to trap_prio_enc.
//   - FSM state encoding of trap_ctrl.
// -----------------------------------------------------------------------------
package trap_pkg;

    localparam int CODE_W = 4;

    localparam logic [CODE_W-1:0] CAUSE_ILLEGAL = 4'd2;
    localparam logic [CODE_W-1:0] CAUSE_EBREAK  = 4'd3;
    localparam logic [CODE_W-1:0] CAUSE_LD_MIS  = 4'd4;
    localparam logic [CODE_W-1:0] CAUSE_ST_MIS  = 4'd6;
    localparam logic [CODE_W-1:0] CAUSE_ECALL_M = 4'd11;

    // Full mcause for a machine external interrupt: interrupt bit + code 11.
    localparam logic [31:0]       CAUSE_IRQ_MEXT = 32'h8000_000B;
    localparam logic [CODE_W-1:0] CAUSE_IRQ_CODE = CAUSE_IRQ_MEXT[CODE_W-1:0];

    // Exception request vector layout.
    localparam int EXC_W       = 5;
    localparam int EXC_ILLEGAL = 4;
    localparam int EXC_EBREAK  = 3;
    localparam int EXC_ECALL   = 2;
    localparam int EXC_LD_MIS  = 1;
    localparam int EXC_ST_MIS  = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_COMMIT = 3'd2,
        ST_REDIR  = 3'd3,
        ST_MRET   = 3'd4
    } trap_state_e;

endpackage

// File: rtl/trap_prio_enc.sv
// -----------------------------------------------------------------------------
// trap_prio_enc
// Combinational priority encoder for synchronous exceptions.
// Priority (high to low): illegal > ebreak > ecall > ld_misalign > st_misalign.
// Ports:
//   i_exc   in  EXC_W   exception requests, bit layout from trap_pkg
//   o_code  out CODE_W  cause code of the winning request (0 when none)
//   o_any   out 1       at least one request is active
// -----------------------------------------------------------------------------
module trap_prio_enc
    import trap_pkg::*;
(
    input  logic [EXC_W-1:0]  i_exc,
    output logic [CODE_W-1:0] o_code,
    output logic              o_any
);

    always_comb begin
        o_code = '0;
        o_any  = |i_exc;
        if (i_exc[EXC_ILLEGAL]) begin
            o_code = CAUSE_ILLEGAL;
        end else if (i_exc[EXC_EBREAK]) begin
            o_code = CAUSE_EBREAK;
        end else if (i_exc[EXC_ECALL]) begin
            o_code = CAUSE_ECALL_M;
        end else if (i_exc[EXC_LD_MIS]) begin
            o_code = CAUSE_LD_MIS;
        end else if (i_exc[EXC_ST_MIS]) begin
            o_code = CAUSE_ST_MIS;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
// Trap sequencer upstream of the CSR unit. Picks the highest-priority
// synchronous exception, drains the pipeline for DRAIN_CYCLES cycles, pulses
// trap_enter with the saved PC/cause, then redirects fetch to mtvec. MRET is
// sequenced in a single cycle: mret_exec + redirect to mepc.
//
// Optional feature macro: TRAP_IRQ_EN (adds ext_irq/mie_in and takes machine
// external interrupts from IDLE; synchronous exceptions win in the same cycle).
//
// Strobe semantics: trap_enter, mret_exec and redirect_valid are one-cycle
// pulses with no back-pressure; trap_pc/trap_cause are meaningful only with
// trap_enter and redirect_pc only with redirect_valid, and read 0 otherwise.
// Requests (exc_*, mret_req, interrupt) are sampled only in IDLE, never queued.
//
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   exc_illegal..exc_st_misalign   synchronous exception requests
//   exc_pc                         PC of the requesting instruction
//   mret_req                       MRET decoded
//   mtvec_in, mepc_in              trap vector / saved PC from the CSR unit
//   ext_irq, mie_in                interrupt request / mstatus.MIE (macro only)
//   flush, stall                   pipeline control
//   trap_enter, trap_pc, trap_cause  trap commit to the CSR unit
//   mret_exec                      MRET commit to the CSR unit
//   redirect_valid, redirect_pc    fetch redirect
//   dbg_state                      current FSM state
// -----------------------------------------------------------------------------
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            exc_illegal,
    input  logic            exc_ebreak,
    input  logic            exc_ecall,
    input  logic            exc_ld_misalign,
    input  logic            exc_st_misalign,
    input  logic [XLEN-1:0] exc_pc,
    input  logic            mret_req,
    input  logic [XLEN-1:0] mtvec_in,
    input  logic [XLEN-1:0] mepc_in,
`ifdef TRAP_IRQ_EN
    input  logic            ext_irq,
    input  logic            mie_in,
`endif
    output logic            flush,
    output logic            stall,
    output logic            trap_enter,
    output logic [XLEN-1:0] trap_pc,
    output logic [XLEN-1:0] trap_cause,
    output logic            mret_exec,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output trap_state_e     dbg_state
);

    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

    trap_state_e       r_state;
    trap_state_e       w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CODE_W-1:0] r_code;
    logic              r_irq;
    logic [XLEN-1:0]   r_pc;

    logic [EXC_W-1:0]  w_exc_vec;
    logic [CODE_W-1:0] w_exc_code;
    logic              w_any_exc;
    logic              w_take_irq;
    logic              w_start;
    logic [XLEN-1:0]   w_cause;

    assign w_exc_vec = {exc_illegal, exc_ebreak, exc_ecall,
                        exc_ld_misalign, exc_st_misalign};

    trap_prio_enc u_prio_enc (
        .i_exc  (w_exc_vec),
        .o_code (w_exc_code),
        .o_any  (w_any_exc)
    );

`ifdef TRAP_IRQ_EN
    assign w_take_irq = ext_irq & mie_in;
`else
    assign w_take_irq = 1'b0;
`endif

    // A trap sequence starts from IDLE on any exception or enabled interrupt.
    assign w_start = (r_state == ST_IDLE) && (w_any_exc || w_take_irq);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture registers and drain counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_code <= '0;
            r_irq  <= 1'b0;
            r_pc   <= '0;
        end else if (w_start) begin
            r_cnt  <= CNT_W'(DRAIN_CYCLES);
            // Exceptions outrank the interrupt in the same cycle.
            r_code <= w_any_exc ? w_exc_code : CAUSE_IRQ_CODE;
            r_irq  <= ~w_any_exc;
            r_pc   <= exc_pc;
        end else if (r_state == ST_DRAIN) begin
            r_cnt  <= r_cnt - CNT_W'(1);
        end
    end

    // Next-state logic. MRET arriving with an exception is dropped.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_exc || w_take_irq) begin
                    w_next_state = ST_DRAIN;
                end else if (mret_req) begin
                    w_next_state = ST_MRET;
                end
            end
            ST_DRAIN: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_next_state = ST_COMMIT;
                end
            end
            ST_COMMIT: w_next_state = ST_REDIR;
            ST_REDIR:  w_next_state = ST_IDLE;
            ST_MRET:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // mcause: zero-extended code, interrupt flag in the MSB.
    always_comb begin
        w_cause              = '0;
        w_cause[CODE_W-1:0]  = r_code;
        w_cause[XLEN-1]      = r_irq;
    end

    // Output logic (Moore, plus mtvec/mepc pass-through while redirecting)
    always_comb begin
        flush          = 1'b0;
        stall          = 1'b0;
        trap_enter     = 1'b0;
        trap_pc        = '0;
        trap_cause     = '0;
        mret_exec      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        case (r_state)
            ST_DRAIN: begin
                flush = 1'b1;
                stall = 1'b1;
            end
            ST_COMMIT: begin
                flush      = 1'b1;
                stall      = 1'b1;
                trap_enter = 1'b1;
                trap_pc    = r_pc;
                trap_cause = w_cause;
            end
            ST_REDIR: begin
                // mtvec is read one cycle after trap_enter so a CSR write
                // performed on the commit cycle is already visible.
                stall          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = mtvec_in;
            end
            ST_MRET: begin
                flush          = 1'b1;
                stall          = 1'b1;
                mret_exec      = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = mepc_in;
            end
            default: ;
        endcase
    end

    assign dbg_state = r_state;

endmodule

// File: tb/tb_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trap_ctrl
// Self-checking bench for trap_ctrl (XLEN=32, DRAIN_CYCLES=2).
// Directed table of single requests, hand-written timing/abort sequences and
// random request streams checked against a timeline model of the trap rules.
// Build with +define+TRAP_IRQ_EN to cover the interrupt path.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_trap_ctrl;
    import trap_pkg::*;

    localparam int XLEN = 32;
    localparam int D    = 2;
    localparam int NS   = 200;
    localparam int TAIL = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic            exc_illegal, exc_ebreak, exc_ecall, exc_ld_misalign, exc_st_misalign;
    logic [XLEN-1:0] exc_pc, mtvec_in, mepc_in;
    logic            mret_req;
    logic            ext_irq, mie_in;
    logic            flush, stall, trap_enter, mret_exec, redirect_valid;
    logic [XLEN-1:0] trap_pc, trap_cause, redirect_pc;
    trap_state_e     dbg_state;

    trap_ctrl #(.XLEN(XLEN), .DRAIN_CYCLES(D)) dut (
        .clk             (clk),
        .rst             (rst),
        .exc_illegal     (exc_illegal),
        .exc_ebreak      (exc_ebreak),
        .exc_ecall       (exc_ecall),
        .exc_ld_misalign (exc_ld_misalign),
        .exc_st_misalign (exc_st_misalign),
        .exc_pc          (exc_pc),
        .mret_req        (mret_req),
        .mtvec_in        (mtvec_in),
        .mepc_in         (mepc_in),
`ifdef TRAP_IRQ_EN
        .ext_irq         (ext_irq),
        .mie_in          (mie_in),
`endif
        .flush           (flush),
        .stall           (stall),
        .trap_enter      (trap_enter),
        .trap_pc         (trap_pc),
        .trap_cause      (trap_cause),
        .mret_exec       (mret_exec),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .dbg_state       (dbg_state)
    );

    // ---------------- types / scoreboard ----------------
    // exc bit 4..0 = illegal, ebreak, ecall, ld_misalign, st_misalign
    typedef struct {
        logic [4:0]  exc;
        logic        mret;
        logic        irq;
        logic        mie;
        logic [31:0] pc;
        logic [31:0] mtvec;
        logic [31:0] mepc;
    } stim_t;

    typedef logic [100:0] obs_t;   // {flush,stall,te,mret,rv,tpc,tcause,rpc}

    typedef struct {
        stim_t       s;
        int          exp_te;
        logic [31:0] exp_cause;
        logic [31:0] exp_pc;
        int          exp_mret;
        logic [31:0] exp_rpc;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    stim_t st [NS+TAIL];
    obs_t  ex [NS+TAIL];

    function automatic obs_t mk(logic f, logic s, logic te, logic me, logic rv,
                                logic [31:0] tpc, logic [31:0] tca, logic [31:0] rpc);
        return {f, s, te, me, rv, tpc, tca, rpc};
    endfunction

    function automatic obs_t dut_obs();
        return {flush, stall, trap_enter, mret_exec, redirect_valid,
                trap_pc, trap_cause, redirect_pc};
    endfunction

    function automatic stim_t mk_stim(logic [4:0] exc, logic mret, logic irq, logic mie,
                                      logic [31:0] pc, logic [31:0] mtvec, logic [31:0] mepc);
        stim_t s;
        s.exc = exc; s.mret = mret; s.irq = irq; s.mie = mie;
        s.pc = pc; s.mtvec = mtvec; s.mepc = mepc;
        return s;
    endfunction

    task automatic check_obs(string name, obs_t act, obs_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_val(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(stim_t s);
        exc_illegal     = s.exc[4];
        exc_ebreak      = s.exc[3];
        exc_ecall       = s.exc[2];
        exc_ld_misalign = s.exc[1];
        exc_st_misalign = s.exc[0];
        mret_req        = s.mret;
        exc_pc          = s.pc;
        mtvec_in        = s.mtvec;
        mepc_in         = s.mepc;
        ext_irq         = s.irq;
        mie_in          = s.mie;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in IDLE at 1 ns after a rising edge: the start of cycle 0.
    task automatic do_reset();
        drive(mk_stim(5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h100, 32'h0));
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    // Apply one request for one cycle, then watch 10 cycles and summarize.
    task automatic apply_collect(stim_t s, output int te_n, output logic [31:0] cause,
                                 output logic [31:0] pc, output int mret_n,
                                 output logic [31:0] rpc);
        stim_t idle_s;
        te_n = 0; mret_n = 0; cause = '0; pc = '0; rpc = '0;
        idle_s = mk_stim(5'd0, 1'b0, 1'b0, 1'b0, 32'h0, s.mtvec, s.mepc);
        drive(s);
        step();
        drive(idle_s);
        for (int k = 0; k < 10; k++) begin
            if (trap_enter === 1'b1) begin
                te_n++; cause = trap_cause; pc = trap_pc;
            end
            if (mret_exec === 1'b1) mret_n++;
            if (redirect_valid === 1'b1) rpc = redirect_pc;
            step();
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_cause(logic [4:0] exc);
        if (exc[4]) return 32'd2;
        if (exc[3]) return 32'd3;
        if (exc[2]) return 32'd11;
        if (exc[1]) return 32'd4;
        return 32'd6;
    endfunction

    // Builds the expected output timeline: an accepted request at cycle c
    // books the following cycles; requests arriving before free_at are lost.
    task automatic build_model(int n);
        int free_at;
        free_at = 0;
        for (int c = 0; c < n + TAIL; c++) ex[c] = '0;
        for (int c = 0; c < n; c++) begin
            logic        take;
            logic [31:0] cause;
            take  = 1'b0;
            cause = '0;
            if (c < free_at) continue;
            if (st[c].exc != 5'd0) begin
                take  = 1'b1;
                cause = model_cause(st[c].exc);
            end
`ifdef TRAP_IRQ_EN
            else if (st[c].irq && st[c].mie) begin
                take  = 1'b1;
                cause = 32'h8000_000B;
            end
`endif
            if (take) begin
                for (int k = 1; k <= D; k++)
                    ex[c+k] = mk(1, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0);
                ex[c+D+1] = mk(1, 1, 1, 0, 0, st[c].pc, cause, 32'h0);
                ex[c+D+2] = mk(0, 1, 0, 0, 1, 32'h0, 32'h0, st[c+D+2].mtvec);
                free_at   = c + D + 3;
            end else if (st[c].mret) begin
                ex[c+1] = mk(1, 1, 0, 1, 1, 32'h0, 32'h0, st[c+1].mepc);
                free_at = c + 2;
            end
        end
    endtask

    task automatic fill_random(int n);
        for (int c = 0; c < n + TAIL; c++) begin
            st[c].exc   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            st[c].mret  = ($urandom_range(0, 4) == 0);
            st[c].irq   = ($urandom_range(0, 3) == 0);
            st[c].mie   = 1'($urandom_range(0, 1));
            st[c].pc    = $urandom & 32'hFFFF_FFFC;
            st[c].mtvec = $urandom & 32'hFFFF_FFFC;
            st[c].mepc  = $urandom & 32'hFFFF_FFFC;
            if (c >= n) begin
                st[c].exc = 5'd0; st[c].mret = 1'b0; st[c].irq = 1'b0;
            end
        end
    endtask

    task automatic run_stream(int n, string tag);
        for (int c = 0; c < n + TAIL; c++) begin
            drive(st[c]);
            #1;
            check_obs($sformatf("%s_c%0d", tag, c), dut_obs(), ex[c]);
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- test ----------------
    vec_t vecs [8];

    initial begin
        int          te_n, mret_n;
        logic [31:0] cause, pc, rpc;

        vecs[0] = '{mk_stim(5'b00100, 0, 0, 0, 32'h40, 32'h100, 32'h0),  1, 32'd11, 32'h40, 0, 32'h100};
        vecs[1] = '{mk_stim(5'b10001, 0, 0, 0, 32'h80, 32'h100, 32'h0),  1, 32'd2,  32'h80, 0, 32'h100};
        vecs[2] = '{mk_stim(5'b00000, 1, 0, 0, 32'h90, 32'h100, 32'h44), 0, 32'd0,  32'h0,  1, 32'h44};
        vecs[3] = '{mk_stim(5'b01000, 1, 0, 0, 32'h48, 32'h100, 32'h44), 1, 32'd3,  32'h48, 0, 32'h100};
        vecs[4] = '{mk_stim(5'b00011, 0, 0, 0, 32'hA0, 32'h200, 32'h0),  1, 32'd4,  32'hA0, 0, 32'h200};
        vecs[5] = '{mk_stim(5'b00001, 0, 0, 0, 32'hA4, 32'h200, 32'h0),  1, 32'd6,  32'hA4, 0, 32'h200};
        vecs[6] = '{mk_stim(5'b01110, 0, 0, 0, 32'hA8, 32'h300, 32'h0),  1, 32'd3,  32'hA8, 0, 32'h300};
        vecs[7] = '{mk_stim(5'b00000, 0, 0, 0, 32'hAC, 32'h300, 32'h50), 0, 32'd0,  32'h0,  0, 32'h0};

        do_reset();
        check_obs("reset_outputs", dut_obs(), '0);

        // Directed table
        foreach (vecs[i]) begin
            apply_collect(vecs[i].s, te_n, cause, pc, mret_n, rpc);
            check_val($sformatf("vec%0d_te_count", i),   32'(te_n),   32'(vecs[i].exp_te));
            check_val($sformatf("vec%0d_cause", i),      cause,       vecs[i].exp_cause);
            check_val($sformatf("vec%0d_trap_pc", i),    pc,          vecs[i].exp_pc);
            check_val($sformatf("vec%0d_mret_count", i), 32'(mret_n), 32'(vecs[i].exp_mret));
            check_val($sformatf("vec%0d_redir_pc", i),   rpc,         vecs[i].exp_rpc);
        end

        // Exact exception latency: ecall at cycle 0, pc 0x40, mtvec 0x100
        do_reset();
        drive(mk_stim(5'b00100, 0, 0, 0, 32'h40, 32'h100, 32'h0));
        #1 check_obs("lat_c0", dut_obs(), '0);
        step();
        drive(mk_stim(5'b00000, 0, 0, 0, 32'h0, 32'h100, 32'h0));
        #1 check_obs("lat_c1", dut_obs(), mk(1, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0));
        step();
        check_obs("lat_c2", dut_obs(), mk(1, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0));
        step();
        check_obs("lat_c3", dut_obs(), mk(1, 1, 1, 0, 0, 32'h40, 32'd11, 32'h0));
        step();
        check_obs("lat_c4", dut_obs(), mk(0, 1, 0, 0, 1, 32'h0, 32'h0, 32'h100));
        step();
        check_obs("lat_c5", dut_obs(), '0);

        // MRET latency: mret_exec at cycle 1, idle at cycle 2
        drive(mk_stim(5'b00000, 1, 0, 0, 32'h0, 32'h100, 32'h44));
        step();
        drive(mk_stim(5'b00000, 0, 0, 0, 32'h0, 32'h100, 32'h44));
        #1 check_obs("mret_c1", dut_obs(), mk(1, 1, 0, 1, 1, 32'h0, 32'h0, 32'h44));
        step();
        check_obs("mret_c2", dut_obs(), '0);

        // ecall held through the whole sequence: only one trap
        do_reset();
        te_n = 0;
        for (int c = 0; c < 12; c++) begin
            drive(mk_stim((c <= D + 2) ? 5'b00100 : 5'b00000, 0, 0, 0, 32'h60, 32'h100, 32'h0));
            #1;
            if (trap_enter === 1'b1) te_n++;
            step();
        end
        check_val("ignore_in_drain_te_count", 32'(te_n), 32'd1);

        // Asynchronous reset during DRAIN
        do_reset();
        drive(mk_stim(5'b00100, 0, 0, 0, 32'h70, 32'h100, 32'h0));
        step();
        drive(mk_stim(5'b00000, 0, 0, 0, 32'h0, 32'h100, 32'h0));
        #1 check_obs("abort_pre", dut_obs(), mk(1, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0));
        #1 rst = 1'b0;
        #1 check_obs("abort_async", dut_obs(), '0);
        step();
        rst = 1'b1;
        te_n = 0;
        for (int c = 0; c < 8; c++) begin
            if (trap_enter === 1'b1) te_n++;
            step();
        end
        check_val("abort_te_count", 32'(te_n), 32'd0);

`ifdef TRAP_IRQ_EN
        do_reset();
        apply_collect(mk_stim(5'b00000, 0, 1, 1, 32'h200, 32'h100, 32'h0), te_n, cause, pc, mret_n, rpc);
        check_val("irq_cause", cause, 32'h8000_000B);
        check_val("irq_pc", pc, 32'h200);
        apply_collect(mk_stim(5'b00000, 0, 1, 0, 32'h204, 32'h100, 32'h0), te_n, cause, pc, mret_n, rpc);
        check_val("irq_masked_te_count", 32'(te_n), 32'd0);
        apply_collect(mk_stim(5'b10000, 0, 1, 1, 32'h208, 32'h100, 32'h0), te_n, cause, pc, mret_n, rpc);
        check_val("irq_vs_exc_cause", cause, 32'd2);
`endif

        // Random streams against the timeline model
        for (int r = 0; r < 3; r++) begin
            fill_random(NS);
            build_model(NS);
            do_reset();
            run_stream(NS, $sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard time limit in case the clocking ever stalls
    initial begin
        #2000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
